// File: rtl/cpu_pkg.sv
// Shared RV32I decode constants: execute opcodes, major opcodes, branch funct3
// codes and the ALU opcode selector used by the issue stage.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_BEQ  = 4'd10;
  localparam logic [3:0] ALU_BNE  = 4'd11;
  localparam logic [3:0] ALU_BLT  = 4'd12;
  localparam logic [3:0] ALU_BLTU = 4'd13;
  localparam logic [3:0] ALU_BGE  = 4'd14;
  localparam logic [3:0] ALU_BGEU = 4'd15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // alt is funct7[5]; it only selects SUB for register-register ops, SRA for both.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt,
                                         input logic is_reg);
    case (f3)
      3'b000:  alu_sel = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate extraction: sign-extended I/S/B/U/J immediates from the
// instruction word (the major opcode bits are not needed here).
module imm_gen (
  input  logic [31:7] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/id_ex_issue.sv
// RV32I decode-and-issue stage with a single-entry ID/EX register.
// Optional load-use interlock enabled by defining LOAD_USE_STALL_EN.
import cpu_pkg::*;

module id_ex_issue #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [3:0]      ex_aluop,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rd,
  output logic            ex_wb_en,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic [2:0]      ex_funct3,
  output logic            ex_is_branch,
  output logic            ex_is_jump,
  output logic [XLEN-1:0] ex_target,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode_p0;
  logic [2:0]  f3_p0;
  logic [4:0]  rd_p0;
  logic [3:0]  aluop_p0;
  logic [XLEN-1:0] a_p0, b_p0, tgt_p0;
  logic        wb_req_p0, wb_en_p0, mem_rd_p0, mem_wr_p0, br_p0, jmp_p0, ill_p0;

  logic            vld_p1;
  logic [3:0]      aluop_p1;
  logic [XLEN-1:0] a_p1, b_p1, rs2_p1, tgt_p1, pc_p1;
  logic [4:0]      rd_p1;
  logic [2:0]      f3_p1;
  logic            wb_en_p1, mem_rd_p1, mem_wr_p1, br_p1, jmp_p1, ill_p1;

  logic hazard, xfer;

  imm_gen u_imm_gen (
    .instr (id_instr[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  assign opcode_p0 = id_instr[6:0];
  assign f3_p0     = id_instr[14:12];
  assign rd_p0     = id_instr[11:7];

  // ---- stage p0: combinational decode ----
  always_comb begin
    aluop_p0  = ALU_ADD;
    a_p0      = '0;
    b_p0      = '0;
    tgt_p0    = '0;
    wb_req_p0 = 1'b0;
    mem_rd_p0 = 1'b0;
    mem_wr_p0 = 1'b0;
    br_p0     = 1'b0;
    jmp_p0    = 1'b0;
    ill_p0    = 1'b0;
    case (opcode_p0)
      OPC_OP: begin
        a_p0      = id_rs1_data;
        b_p0      = id_rs2_data;
        aluop_p0  = alu_sel(f3_p0, id_instr[30], 1'b1);
        wb_req_p0 = 1'b1;
      end
      OPC_OP_IMM: begin
        a_p0      = id_rs1_data;
        b_p0      = (f3_p0 == 3'b001 || f3_p0 == 3'b101)
                    ? {{(XLEN-5){1'b0}}, id_instr[24:20]} : imm_i;
        aluop_p0  = alu_sel(f3_p0, id_instr[30], 1'b0);
        wb_req_p0 = 1'b1;
      end
      OPC_LUI: begin
        b_p0      = imm_u;
        wb_req_p0 = 1'b1;
      end
      OPC_AUIPC: begin
        a_p0      = id_pc;
        b_p0      = imm_u;
        wb_req_p0 = 1'b1;
      end
      OPC_LOAD: begin
        a_p0      = id_rs1_data;
        b_p0      = imm_i;
        mem_rd_p0 = 1'b1;
        wb_req_p0 = 1'b1;
      end
      OPC_STORE: begin
        a_p0      = id_rs1_data;
        b_p0      = imm_s;
        mem_wr_p0 = 1'b1;
      end
      OPC_BRANCH: begin
        if (f3_p0 == 3'b010 || f3_p0 == 3'b011) begin
          ill_p0 = 1'b1;
        end else begin
          a_p0   = id_rs1_data;
          b_p0   = id_rs2_data;
          tgt_p0 = id_pc + imm_b;
          br_p0  = 1'b1;
          case (f3_p0)
            F3_BEQ:  aluop_p0 = ALU_BEQ;
            F3_BNE:  aluop_p0 = ALU_BNE;
            F3_BLT:  aluop_p0 = ALU_BLT;
            F3_BGE:  aluop_p0 = ALU_BGE;
            F3_BLTU: aluop_p0 = ALU_BLTU;
            default: aluop_p0 = ALU_BGEU;
          endcase
        end
      end
      OPC_JAL: begin
        a_p0      = id_pc;
        b_p0      = 32'd4;
        tgt_p0    = id_pc + imm_j;
        jmp_p0    = 1'b1;
        wb_req_p0 = 1'b1;
      end
      OPC_JALR: begin
        a_p0      = id_pc;
        b_p0      = 32'd4;
        tgt_p0    = (id_rs1_data + imm_i) & ~32'd1;
        jmp_p0    = 1'b1;
        wb_req_p0 = 1'b1;
      end
      default: ill_p0 = 1'b1;
    endcase
  end

  assign wb_en_p0 = wb_req_p0 && (rd_p0 != 5'd0);

`ifdef LOAD_USE_STALL_EN
  logic use_rs1_p0, use_rs2_p0;

  always_comb begin
    use_rs1_p0 = 1'b0;
    use_rs2_p0 = 1'b0;
    case (opcode_p0)
      OPC_OP, OPC_STORE, OPC_BRANCH: begin
        use_rs1_p0 = 1'b1;
        use_rs2_p0 = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: use_rs1_p0 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = vld_p1 && mem_rd_p1 && (rd_p1 != 5'd0) &&
                  ((use_rs1_p0 && (id_instr[19:15] == rd_p1)) ||
                   (use_rs2_p0 && (id_instr[24:20] == rd_p1)));
`else
  assign hazard = 1'b0;
`endif

  // Flush forces ready so fetch can discard whatever it is offering.
  assign id_ready = flush || ((!vld_p1 || ex_ready) && !hazard);
  assign xfer     = id_valid && id_ready && !flush;

  // ---- stage p1: ID/EX register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      aluop_p1  <= '0;
      a_p1      <= '0;
      b_p1      <= '0;
      rs2_p1    <= '0;
      rd_p1     <= '0;
      f3_p1     <= '0;
      wb_en_p1  <= 1'b0;
      mem_rd_p1 <= 1'b0;
      mem_wr_p1 <= 1'b0;
      br_p1     <= 1'b0;
      jmp_p1    <= 1'b0;
      tgt_p1    <= '0;
      pc_p1     <= RESET_PC;
      ill_p1    <= 1'b0;
    end else begin
      if (flush)         vld_p1 <= 1'b0;
      else if (xfer)     vld_p1 <= 1'b1;
      else if (ex_ready) vld_p1 <= 1'b0;
      if (xfer) begin
        aluop_p1  <= aluop_p0;
        a_p1      <= a_p0;
        b_p1      <= b_p0;
        rs2_p1    <= id_rs2_data;
        rd_p1     <= rd_p0;
        f3_p1     <= f3_p0;
        wb_en_p1  <= wb_en_p0;
        mem_rd_p1 <= mem_rd_p0;
        mem_wr_p1 <= mem_wr_p0;
        br_p1     <= br_p0;
        jmp_p1    <= jmp_p0;
        tgt_p1    <= tgt_p0;
        pc_p1     <= id_pc;
        ill_p1    <= ill_p0;
      end
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_aluop     = aluop_p1;
  assign ex_a         = a_p1;
  assign ex_b         = b_p1;
  assign ex_rs2_data  = rs2_p1;
  assign ex_rd        = rd_p1;
  assign ex_wb_en     = wb_en_p1;
  assign ex_mem_rd    = mem_rd_p1;
  assign ex_mem_wr    = mem_wr_p1;
  assign ex_funct3    = f3_p1;
  assign ex_is_branch = br_p1;
  assign ex_is_jump   = jmp_p1;
  assign ex_target    = tgt_p1;
  assign ex_pc        = vld_p1 ? pc_p1 : RESET_PC;
  assign ex_illegal   = ill_p1;

endmodule

// File: tb/tb_id_ex_issue.sv
// Self-checking bench for id_ex_issue: directed scenarios plus a scoreboard of
// expected ID/EX contents pushed on each accepted instruction.
module tb_id_ex_issue;

  typedef struct packed {
    logic [3:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wb_en;
    logic        mem_rd;
    logic        mem_wr;
    logic        br;
    logic        jmp;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [31:0] id_instr = '0;
  logic [31:0] id_pc = '0;
  logic [31:0] id_rs1_data = '0;
  logic [31:0] id_rs2_data = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;
  logic        ex_valid;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_a, ex_b, ex_rs2_data, ex_target, ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_wb_en, ex_mem_rd, ex_mem_wr, ex_is_branch, ex_is_jump, ex_illegal;
  logic [2:0]  ex_funct3;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_in;
  exp_t sbq[$];

  localparam logic [31:0] R1 = 32'h0000_1010;
  localparam logic [31:0] R2 = 32'h0000_0022;

  always #5 clk = ~clk;

  id_ex_issue dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_funct3(ex_funct3),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_target(ex_target),
    .ex_pc(ex_pc), .ex_illegal(ex_illegal)
  );

  function automatic exp_t mk(input logic [3:0] aluop, input logic [31:0] a, b, rs2,
                              input logic [4:0] rd, input logic [2:0] f3,
                              input logic wb, mrd, mwr, br, jmp,
                              input logic [31:0] tgt, pc, input logic ill);
    exp_t e;
    e.aluop = aluop; e.a = a; e.b = b; e.rs2 = rs2; e.rd = rd; e.f3 = f3;
    e.wb_en = wb; e.mem_rd = mrd; e.mem_wr = mwr; e.br = br; e.jmp = jmp;
    e.tgt = tgt; e.pc = pc; e.ill = ill;
    return e;
  endfunction

  task automatic drive(input logic [31:0] instr, pc, r1, r2, input exp_t e);
    id_instr = instr; id_pc = pc; id_rs1_data = r1; id_rs2_data = r2; exp_in = e;
  endtask

  // One clock: scoreboard pop on consumption, push on acceptance, then the edge.
  task automatic tick(output bit xfered);
    exp_t got, e;
    #1;
    xfered = 1'b0;
    if (!rst && ex_valid && flush) begin
      if (sbq.size() > 0) void'(sbq.pop_front());
    end else if (!rst && ex_valid && ex_ready) begin
      got.aluop = ex_aluop; got.a = ex_a; got.b = ex_b; got.rs2 = ex_rs2_data;
      got.rd = ex_rd; got.f3 = ex_funct3; got.wb_en = ex_wb_en; got.mem_rd = ex_mem_rd;
      got.mem_wr = ex_mem_wr; got.br = ex_is_branch; got.jmp = ex_is_jump;
      got.tgt = ex_target; got.pc = ex_pc; got.ill = ex_illegal;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got %h want none", got);
      end else begin
        e = sbq.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL sb_issue got %h want %h", got, e);
        end
      end
    end
    if (!rst && !flush && id_valid && id_ready) begin
      sbq.push_back(exp_in);
      xfered = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit x;
    rst = 1'b1; flush = 1'b1; id_valid = 1'b1; ex_ready = 1'b1;
    drive(32'h002081B3, 32'h40, 32'd5, 32'd7, exp_in);
    tick(x); tick(x);
    checks++;
    if ({ex_valid, ex_aluop, ex_a, ex_b, ex_rs2_data, ex_rd, ex_wb_en, ex_mem_rd, ex_mem_wr,
         ex_funct3, ex_is_branch, ex_is_jump, ex_target, ex_illegal} !== '0) begin
      errors++;
      $display("FAIL reset_zero got vld=%b op=%h a=%h b=%h tgt=%h want all 0",
               ex_valid, ex_aluop, ex_a, ex_b, ex_target);
    end
    checks++;
    if (ex_pc !== 32'h0) begin
      errors++; $display("FAIL reset_pc got %h want 00000000", ex_pc);
    end
    rst = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", id_ready);
    end
  endtask

  task automatic test_alu();
    bit x;
    drive(32'h002081B3, 32'h200, 32'd5, 32'd7,
          mk(4'd0, 32'd5, 32'd7, 32'd7, 5'd3, 3'd0, 1, 0, 0, 0, 0, 32'h0, 32'h200, 0));
    id_valid = 1'b1; ex_ready = 1'b0;
    tick(x);
    checks++;
    if ({ex_valid, ex_aluop, ex_a, ex_b, ex_rd, ex_wb_en} !==
        {1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1}) begin
      errors++;
      $display("FAIL add_issue got vld=%b op=%0d a=%h b=%h rd=%0d wb=%b want 1 0 5 7 3 1",
               ex_valid, ex_aluop, ex_a, ex_b, ex_rd, ex_wb_en);
    end
    drive(32'h402081B3, 32'h204, 32'd9, 32'd7,
          mk(4'd1, 32'd9, 32'd7, 32'd7, 5'd3, 3'd0, 1, 0, 0, 0, 0, 32'h0, 32'h204, 0));
    ex_ready = 1'b1;
    tick(x);
    checks++;
    if (ex_aluop !== 4'd1 || ex_a !== 32'd9) begin
      errors++; $display("FAIL sub_issue got op=%0d a=%h want 1 9", ex_aluop, ex_a);
    end
    id_valid = 1'b0;
    tick(x);
    checks++;
    if (ex_valid !== 1'b0 || ex_a !== 32'd9) begin
      errors++; $display("FAIL drain got vld=%b a=%h want 0 9", ex_valid, ex_a);
    end
  endtask

  task automatic test_branch();
    bit x;
    drive(32'hFE20DCE3, 32'h100, 32'hFFFF_FFFD, 32'd2,
          mk(4'd14, 32'hFFFF_FFFD, 32'd2, 32'd2, 5'd25, 3'd5, 0, 0, 0, 1, 0, 32'hF8, 32'h100, 0));
    id_valid = 1'b1; ex_ready = 1'b1;
    tick(x);
    checks++;
    if ({ex_valid, ex_aluop, ex_is_branch, ex_target, ex_wb_en} !==
        {1'b1, 4'd14, 1'b1, 32'hF8, 1'b0}) begin
      errors++;
      $display("FAIL bge_issue got vld=%b op=%0d br=%b tgt=%h wb=%b want 1 14 1 f8 0",
               ex_valid, ex_aluop, ex_is_branch, ex_target, ex_wb_en);
    end
    id_valid = 1'b0;
    tick(x);
  endtask

  task automatic test_hold();
    bit x;
    drive(32'h002081B3, 32'h300, 32'd5, 32'd7,
          mk(4'd0, 32'd5, 32'd7, 32'd7, 5'd3, 3'd0, 1, 0, 0, 0, 0, 32'h0, 32'h300, 0));
    id_valid = 1'b1; ex_ready = 1'b0;
    tick(x);
    drive(32'h402081B3, 32'h304, 32'h11, 32'h22,
          mk(4'd1, 32'h11, 32'h22, 32'h22, 5'd3, 3'd0, 1, 0, 0, 0, 0, 32'h0, 32'h304, 0));
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (id_ready !== 1'b0) begin
        errors++; $display("FAIL hold_ready cycle %0d got %b want 0", i, id_ready);
      end
      tick(x);
      checks++;
      if ({ex_valid, ex_aluop, ex_a, ex_pc} !== {1'b1, 4'd0, 32'd5, 32'h300}) begin
        errors++;
        $display("FAIL hold_stable cycle %0d got vld=%b op=%0d a=%h pc=%h want 1 0 5 300",
                 i, ex_valid, ex_aluop, ex_a, ex_pc);
      end
    end
    ex_ready = 1'b1;
    tick(x);
    checks++;
    if ({ex_valid, ex_aluop, ex_a} !== {1'b1, 4'd1, 32'h11}) begin
      errors++;
      $display("FAIL hold_release got vld=%b op=%0d a=%h want 1 1 11", ex_valid, ex_aluop, ex_a);
    end
    id_valid = 1'b0;
    tick(x);
  endtask

  task automatic test_flush();
    bit x;
    drive(32'h002081B3, 32'h380, 32'd1, 32'd2,
          mk(4'd0, 32'd1, 32'd2, 32'd2, 5'd3, 3'd0, 1, 0, 0, 0, 0, 32'h0, 32'h380, 0));
    id_valid = 1'b1; ex_ready = 1'b0;
    tick(x);
    drive(32'h004100E7, 32'h300, 32'h201, 32'h0,
          mk(4'd0, 32'h300, 32'd4, 32'h0, 5'd1, 3'd0, 1, 0, 0, 0, 1, 32'h204, 32'h300, 0));
    flush = 1'b1;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ready got %b want 1", id_ready);
    end
    tick(x);
    flush = 1'b0; id_valid = 1'b0;
    #1;
    checks++;
    if ({ex_valid, id_ready, ex_pc} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL flush_kill got vld=%b rdy=%b pc=%h want 0 1 0", ex_valid, id_ready, ex_pc);
    end
    id_valid = 1'b1; ex_ready = 1'b1;
    tick(x);
    checks++;
    if ({ex_valid, ex_is_jump, ex_target, ex_a, ex_b} !==
        {1'b1, 1'b1, 32'h204, 32'h300, 32'd4}) begin
      errors++;
      $display("FAIL jalr_replay got vld=%b j=%b tgt=%h a=%h b=%h want 1 1 204 300 4",
               ex_valid, ex_is_jump, ex_target, ex_a, ex_b);
    end
    id_valid = 1'b0;
    tick(x);
  endtask

  task automatic test_illegal();
    bit x;
    drive(32'h0000_0FFF, 32'h600, R1, R2,
          mk(4'd0, 32'h0, 32'h0, R2, 5'd31, 3'd0, 0, 0, 0, 0, 0, 32'h0, 32'h600, 1));
    id_valid = 1'b1; ex_ready = 1'b1;
    tick(x);
    checks++;
    if ({ex_valid, ex_illegal, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_aluop} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL illegal_op got vld=%b ill=%b wb=%b mrd=%b mwr=%b op=%0d want 1 1 0 0 0 0",
               ex_valid, ex_illegal, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_aluop);
    end
    drive(32'h0000_2063, 32'h604, R1, R2,
          mk(4'd0, 32'h0, 32'h0, R2, 5'd0, 3'd2, 0, 0, 0, 0, 0, 32'h0, 32'h604, 1));
    tick(x);
    checks++;
    if ({ex_valid, ex_illegal, ex_is_branch} !== {1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL illegal_br got vld=%b ill=%b br=%b want 1 1 0",
               ex_valid, ex_illegal, ex_is_branch);
    end
    id_valid = 1'b0;
    tick(x);
  endtask

  task automatic test_back_to_back();
    logic [31:0] instr [13];
    exp_t        tbl [13];
    int          idx = 0;
    int          cyc = 0;
    bit          x;
    instr[0]  = 32'hFFF08213; tbl[0]  = mk(4'd0,  R1, 32'hFFFF_FFFF, R2, 5'd4,  3'd0, 1, 0, 0, 0, 0, 32'h0,   32'h400, 0);
    instr[1]  = 32'h4030D293; tbl[1]  = mk(4'd7,  R1, 32'd3,         R2, 5'd5,  3'd5, 1, 0, 0, 0, 0, 32'h0,   32'h404, 0);
    instr[2]  = 32'h12345337; tbl[2]  = mk(4'd0,  32'h0, 32'h1234_5000, R2, 5'd6, 3'd5, 1, 0, 0, 0, 0, 32'h0, 32'h408, 0);
    instr[3]  = 32'h00001397; tbl[3]  = mk(4'd0,  32'h40C, 32'h1000,  R2, 5'd7,  3'd1, 1, 0, 0, 0, 0, 32'h0,   32'h40C, 0);
    instr[4]  = 32'hFFC0A403; tbl[4]  = mk(4'd0,  R1, 32'hFFFF_FFFC, R2, 5'd8,  3'd2, 1, 1, 0, 0, 0, 32'h0,   32'h410, 0);
    instr[5]  = 32'h0020A423; tbl[5]  = mk(4'd0,  R1, 32'd8,         R2, 5'd8,  3'd2, 0, 0, 1, 0, 0, 32'h0,   32'h414, 0);
    instr[6]  = 32'h010000EF; tbl[6]  = mk(4'd0,  32'h418, 32'd4,    R2, 5'd1,  3'd0, 1, 0, 0, 0, 1, 32'h428, 32'h418, 0);
    instr[7]  = 32'h0020A4B3; tbl[7]  = mk(4'd8,  R1, R2,            R2, 5'd9,  3'd2, 1, 0, 0, 0, 0, 32'h0,   32'h41C, 0);
    instr[8]  = 32'h00000013; tbl[8]  = mk(4'd0,  R1, 32'd0,         R2, 5'd0,  3'd0, 0, 0, 0, 0, 0, 32'h0,   32'h420, 0);
    instr[9]  = 32'h00209663; tbl[9]  = mk(4'd11, R1, R2,            R2, 5'd12, 3'd1, 0, 0, 0, 1, 0, 32'h430, 32'h424, 0);
    instr[10] = 32'h4020D533; tbl[10] = mk(4'd7,  R1, R2,            R2, 5'd10, 3'd5, 1, 0, 0, 0, 0, 32'h0,   32'h428, 0);
    instr[11] = 32'h0040D593; tbl[11] = mk(4'd6,  R1, 32'd4,         R2, 5'd11, 3'd5, 1, 0, 0, 0, 0, 32'h0,   32'h42C, 0);
    instr[12] = 32'h8000F613; tbl[12] = mk(4'd2,  R1, 32'hFFFF_F800, R2, 5'd12, 3'd7, 1, 0, 0, 0, 0, 32'h0,   32'h430, 0);
    while (idx < 13 && cyc < 400) begin
      drive(instr[idx], 32'h400 + 32'(idx) * 4, R1, R2, tbl[idx]);
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      tick(x);
      if (x) idx++;
      cyc++;
    end
    checks++;
    if (idx != 13) begin
      errors++; $display("FAIL stream_accept got %0d want 13", idx);
    end
    id_valid = 1'b0; ex_ready = 1'b1;
    for (int i = 0; i < 8 && ex_valid; i++) tick(x);
    checks++;
    if (ex_valid !== 1'b0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL stream_drain got vld=%b pending=%0d want 0 0", ex_valid, sbq.size());
    end
  endtask

  task automatic test_load_use();
    bit x;
    drive(32'h0000A283, 32'h500, R1, R2,
          mk(4'd0, R1, 32'd0, R2, 5'd5, 3'd2, 1, 1, 0, 0, 0, 32'h0, 32'h500, 0));
    id_valid = 1'b1; ex_ready = 1'b1;
    tick(x);
    drive(32'h00128333, 32'h504, 32'h77, R1,
          mk(4'd0, 32'h77, R1, R1, 5'd6, 3'd0, 1, 0, 0, 0, 0, 32'h0, 32'h504, 0));
    #1;
`ifdef LOAD_USE_STALL_EN
    checks++;
    if (id_ready !== 1'b0) begin
      errors++; $display("FAIL lu_stall got rdy=%b want 0", id_ready);
    end
    tick(x);
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++; $display("FAIL lu_bubble got vld=%b want 0", ex_valid);
    end
    tick(x);
`else
    checks++;
    if (id_ready !== 1'b1) begin
      errors++; $display("FAIL lu_nostall got rdy=%b want 1", id_ready);
    end
    tick(x);
`endif
    checks++;
    if ({ex_valid, ex_rd, ex_a} !== {1'b1, 5'd6, 32'h77}) begin
      errors++;
      $display("FAIL lu_issue got vld=%b rd=%0d a=%h want 1 6 77", ex_valid, ex_rd, ex_a);
    end
    drive(32'h0000A003, 32'h508, R1, R2,
          mk(4'd0, R1, 32'd0, R2, 5'd0, 3'd2, 0, 1, 0, 0, 0, 32'h0, 32'h508, 0));
    tick(x);
    drive(32'h00100333, 32'h50C, 32'h0, R1,
          mk(4'd0, 32'h0, R1, R1, 5'd6, 3'd0, 1, 0, 0, 0, 0, 32'h0, 32'h50C, 0));
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++; $display("FAIL lu_x0 got rdy=%b want 1", id_ready);
    end
    tick(x);
    checks++;
    if ({ex_valid, ex_rd, ex_pc} !== {1'b1, 5'd6, 32'h50C}) begin
      errors++;
      $display("FAIL lu_x0_issue got vld=%b rd=%0d pc=%h want 1 6 50c", ex_valid, ex_rd, ex_pc);
    end
    id_valid = 1'b0;
    tick(x);
  endtask

  initial begin
    exp_in = '0;
    test_reset();
    test_alu();
    test_branch();
    test_hold();
    test_flush();
    test_illegal();
    test_load_use();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
